// File: rtl/meas_tx_framer_if.sv
// meas_tx_framer_if
//   Byte write port into the ft245_async_fifo.
//   wr_en   : write strobe, one byte per cycle while high (master -> slave)
//   wr_data : byte being written                          (master -> slave)
//   wr_full : FIFO full, no write may be issued while high (slave -> master)
interface meas_tx_framer_if;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       wr_full;

    modport master (output wr_en, output wr_data, input wr_full);
    modport slave  (input wr_en, input wr_data, output wr_full);
endinterface

// File: rtl/meas_tx_framer.sv
// meas_tx_framer
//   Uplink framer for the host serial link (CLK_25M domain). Collects SAMPLES
//   12-bit samples, then writes one frame into the FIFO:
//     SYNC, TYPE, {0,op_mode}, seq, 2*SAMPLES, {0,s[k][11:8]}, s[k][7:0] ..., checksum
//   checksum = mod-256 sum of every byte after SYNC up to the last payload byte.
// Ports
//   clk, reset      : clock, synchronous active-high reset
//   sample_valid    : one-cycle strobe qualifying sample_data
//   sample_data     : 12-bit measurement sample
//   op_mode         : control state, latched with the last sample of a frame
//   tx_enable       : allow collection; low clears a partially collected frame
//   fifo (master)   : wr_en / wr_data / wr_full FIFO write port
//   busy            : high while the frame bytes are being sent
//   frame_done      : one-cycle pulse after the checksum byte is written
//   overflow        : sticky, a sample was dropped while a frame was in flight
module meas_tx_framer #(
    parameter int unsigned SAMPLES   = 8,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter logic [7:0]  TYPE_MEAS = 8'h4D
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_valid,
    input  logic [11:0]      sample_data,
    input  logic [3:0]       op_mode,
    input  logic             tx_enable,
    meas_tx_framer_if.master fifo,
    output logic             busy,
    output logic             frame_done,
    output logic             overflow
);
    localparam int unsigned NBYTES   = 5 + 2 * SAMPLES + 1;
    localparam logic [7:0]  LAST_PTR = 8'(NBYTES - 1);
    localparam logic [7:0]  LEN_BYTE = 8'(2 * SAMPLES);
    localparam logic [6:0]  CNT_LAST = 7'(SAMPLES - 1);

    typedef enum logic [1:0] {COLLECT, SEND, DONE} state_e;

    state_e      state_q;
    logic [6:0]  cnt_q;
    logic        full_q;
    logic [11:0] samp_q [SAMPLES];
    logic [3:0]  mode_q;
    logic [7:0]  seq_q;
    logic [7:0]  ptr_q;
    logic [7:0]  csum_q;
    logic [7:0]  wr_data_q;
    logic        busy_q;
    logic        frame_done_q;
    logic        overflow_q;

    logic [7:0]  ptr_d;
    logic [7:0]  csum_d;
    logic [7:0]  byte_d;
    logic [7:0]  pay_idx;
    logic [11:0] samp_sel;
    logic        samp_we;
    logic        wr_en;

    assign wr_en        = (state_q == SEND) && !fifo.wr_full;
    assign fifo.wr_en   = wr_en;
    assign fifo.wr_data = wr_data_q;
    assign busy         = busy_q;
    assign frame_done   = frame_done_q;
    assign overflow     = overflow_q;

    assign samp_we = (state_q == COLLECT) && !full_q && tx_enable && sample_valid;

    // wr_data_q always holds byte[ptr_q]; on each write the following byte is
    // preloaded, so the checksum byte is the running sum plus the byte going
    // out in the same cycle (SYNC at ptr 0 is left out of the sum).
    always_comb begin
        ptr_d    = ptr_q + 8'd1;
        csum_d   = (ptr_q == 8'd0) ? csum_q : csum_q + wr_data_q;
        pay_idx  = ptr_d - 8'd5;
        samp_sel = '0;
        for (int unsigned k = 0; k < SAMPLES; k++) begin
            if (7'(k) == pay_idx[7:1]) samp_sel = samp_q[k];
        end
        if (ptr_d == LAST_PTR) begin
            byte_d = csum_d;
        end else begin
            case (ptr_d)
                8'd1:    byte_d = TYPE_MEAS;
                8'd2:    byte_d = {4'h0, mode_q};
                8'd3:    byte_d = seq_q;
                8'd4:    byte_d = LEN_BYTE;
                default: byte_d = pay_idx[0] ? samp_sel[7:0] : {4'h0, samp_sel[11:8]};
            endcase
        end
    end

    // Sample store needs no reset; contents are only read after a full collect.
    always_ff @(posedge clk) begin
        if (samp_we) begin
            for (int unsigned k = 0; k < SAMPLES; k++) begin
                if (7'(k) == cnt_q) samp_q[k] <= sample_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= COLLECT;
            cnt_q        <= '0;
            full_q       <= 1'b0;
            mode_q       <= '0;
            seq_q        <= '0;
            ptr_q        <= '0;
            csum_q       <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                COLLECT: begin
                    if (full_q) begin
                        // Buffer complete: one cycle to stage SYNC, so a sample
                        // arriving now has nowhere to go and is dropped.
                        full_q    <= 1'b0;
                        state_q   <= SEND;
                        busy_q    <= 1'b1;
                        ptr_q     <= '0;
                        csum_q    <= '0;
                        wr_data_q <= SYNC_BYTE;
                        if (sample_valid) overflow_q <= 1'b1;
                    end else if (!tx_enable) begin
                        cnt_q <= '0;
                    end else if (sample_valid) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q  <= '0;
                            full_q <= 1'b1;
                            mode_q <= op_mode;
                        end else begin
                            cnt_q <= cnt_q + 7'd1;
                        end
                    end
                end
                SEND: begin
                    if (sample_valid) overflow_q <= 1'b1;
                    if (wr_en) begin
                        if (ptr_q == LAST_PTR) begin
                            state_q      <= DONE;
                            busy_q       <= 1'b0;
                            frame_done_q <= 1'b1;
                        end else begin
                            ptr_q     <= ptr_d;
                            csum_q    <= csum_d;
                            wr_data_q <= byte_d;
                        end
                    end
                end
                DONE: begin
                    if (sample_valid) overflow_q <= 1'b1;
                    seq_q   <= seq_q + 8'd1;
                    cnt_q   <= '0;
                    state_q <= COLLECT;
                end
                default: state_q <= COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_meas_tx_framer.sv
// tb_meas_tx_framer
//   Bench for meas_tx_framer with SAMPLES=2. Frames are captured from the FIFO
//   write port and compared with a frame built from the byte-layout rules.
module tb_meas_tx_framer;
    localparam int unsigned NS = 2;
    localparam int          NB = 5 + 2 * NS + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_valid;
    logic [11:0] sample_data;
    logic [3:0]  op_mode;
    logic        tx_enable;
    logic        busy;
    logic        frame_done;
    logic        overflow;

    meas_tx_framer_if fifo_if();

    meas_tx_framer #(.SAMPLES(NS), .SYNC_BYTE(8'hA5), .TYPE_MEAS(8'h4D)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .op_mode      (op_mode),
        .tx_enable    (tx_enable),
        .fifo         (fifo_if),
        .busy         (busy),
        .frame_done   (frame_done),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    logic [7:0] got[$];
    int         first_wr_cyc, last_wr_cyc, fd_cyc, strobe_cyc;
    bit         fd_seen = 1'b0;
    int         viol = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic [7:0] model_seq = '0;
    logic [7:0] exp_b [NB];

    typedef struct {
        logic [3:0]  mode;
        logic [11:0] s0;
        logic [11:0] s1;
        logic [7:0]  csum;
    } vec_t;
    vec_t tab [4];

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor: capture written bytes, frame_done, and port-rule breaches.
    always @(negedge clk) begin
        if (fifo_if.wr_en === 1'b1) begin
            if (got.size() == 0) first_wr_cyc = cyc;
            got.push_back(fifo_if.wr_data);
            last_wr_cyc = cyc;
        end
        if (frame_done === 1'b1) begin
            fd_seen = 1'b1;
            fd_cyc  = cyc;
        end
        if (fifo_if.wr_en === 1'b1 && (fifo_if.wr_full !== 1'b0 || busy !== 1'b1)) viol++;
        if (prev_stall && busy === 1'b1 && fifo_if.wr_data !== prev_data) viol++;
        prev_stall = (busy === 1'b1) && (fifo_if.wr_full === 1'b1);
        prev_data  = fifo_if.wr_data;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference frame from the byte-layout rules.
    task automatic build_exp(input logic [3:0] mode, input logic [11:0] s0,
                             input logic [11:0] s1, input logic [7:0] seq);
        int sum;
        exp_b[0] = 8'hA5;
        exp_b[1] = 8'h4D;
        exp_b[2] = {4'h0, mode};
        exp_b[3] = seq;
        exp_b[4] = 8'(2 * NS);
        exp_b[5] = {4'h0, s0[11:8]};
        exp_b[6] = s0[7:0];
        exp_b[7] = {4'h0, s1[11:8]};
        exp_b[8] = s1[7:0];
        sum = 0;
        for (int i = 1; i < NB - 1; i++) sum += int'(exp_b[i]);
        exp_b[NB-1] = 8'(sum % 256);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sample_valid = 1'b0;
        sample_data = '0;
        op_mode = '0;
        tx_enable = 1'b0;
        fifo_if.wr_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_seq = '0;
    endtask

    // stall_mode: 0 none, 1 five-cycle full after byte 3, 2 random full + tx_enable
    task automatic run_frame(input logic [3:0] mode, input logic [11:0] s0,
                             input logic [11:0] s1, input int stall_mode,
                             input bit poke, input string tag);
        int stall_left;
        bit poked;
        int a;
        got.delete();
        fd_seen = 1'b0;
        viol = 0;
        stall_left = 5;
        poked = 1'b0;
        tx_enable = 1'b1;
        op_mode = mode;
        sample_valid = 1'b1;
        sample_data = s0;
        @(posedge clk); #1;
        sample_data = s1;
        strobe_cyc = cyc;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        sample_data = '0;
        op_mode = ~mode;
        for (int i = 0; i < 400; i++) begin
            if (fd_seen) break;
            sample_valid = 1'b0;
            case (stall_mode)
                1: begin
                    if (got.size() >= 4 && stall_left > 0) begin
                        fifo_if.wr_full = 1'b1;
                        stall_left--;
                    end else begin
                        fifo_if.wr_full = 1'b0;
                    end
                end
                2: begin
                    fifo_if.wr_full = ($urandom_range(0, 2) == 0);
                    tx_enable = ($urandom_range(0, 1) == 1);
                end
                default: fifo_if.wr_full = 1'b0;
            endcase
            if (poke && busy === 1'b1 && !poked) begin
                sample_valid = 1'b1;
                sample_data = 12'($urandom);
                poked = 1'b1;
            end
            @(posedge clk); #1;
        end
        sample_valid = 1'b0;
        fifo_if.wr_full = 1'b0;
        tx_enable = 1'b1;

        build_exp(mode, s0, s1, model_seq);
        check($sformatf("%s frame_done_seen", tag), int'(fd_seen), 1);
        check($sformatf("%s nbytes", tag), got.size(), NB);
        for (int i = 0; i < NB; i++) begin
            a = (i < got.size()) ? int'(got[i]) : -1;
            check($sformatf("%s byte%0d", tag, i), a, int'(exp_b[i]));
        end
        check($sformatf("%s done_after_last", tag), fd_cyc - last_wr_cyc, 1);
        check($sformatf("%s latency_ge2", tag), (first_wr_cyc - strobe_cyc >= 2) ? 1 : 0, 1);
        check($sformatf("%s port_rules", tag), viol, 0);
        check($sformatf("%s busy_low_after", tag), int'(busy), 0);
        model_seq = model_seq + 8'd1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tab[0] = '{4'h7, 12'h123, 12'hABC, 8'h42};
        tab[1] = '{4'h0, 12'h000, 12'h000, 8'h52};
        tab[2] = '{4'hF, 12'hFFF, 12'hFFF, 8'h7E};
        tab[3] = '{4'h5, 12'h800, 12'h001, 8'h62};

        // Reset state
        do_reset();
        check("rst wr_en", int'(fifo_if.wr_en), 0);
        check("rst wr_data", int'(fifo_if.wr_data), 0);
        check("rst busy", int'(busy), 0);
        check("rst frame_done", int'(frame_done), 0);
        check("rst overflow", int'(overflow), 0);

        // Table-driven frames, sequence 0..3, hand-computed checksums
        for (int i = 0; i < 4; i++) begin
            run_frame(tab[i].mode, tab[i].s0, tab[i].s1, 0, 1'b0, $sformatf("tab%0d", i));
            check($sformatf("tab%0d csum", i), (got.size() == NB) ? int'(got[NB-1]) : -1,
                  int'(tab[i].csum));
        end

        // Full-FIFO stall after byte 3
        do_reset();
        run_frame(4'h7, 12'h123, 12'hABC, 1, 1'b0, "stall");
        check("stall csum", (got.size() == NB) ? int'(got[NB-1]) : -1, 8'h42);

        // Sample during SEND: dropped, sticky overflow
        do_reset();
        check("ovf before", int'(overflow), 0);
        run_frame(4'h2, 12'h456, 12'h789, 0, 1'b1, "ovf");
        check("ovf set", int'(overflow), 1);
        run_frame(4'h2, 12'h001, 12'h002, 0, 1'b0, "ovf2");
        check("ovf sticky", int'(overflow), 1);
        do_reset();
        check("ovf cleared", int'(overflow), 0);

        // Reset after byte 4 abandons the frame
        got.delete();
        fd_seen = 1'b0;
        tx_enable = 1'b1;
        op_mode = 4'h3;
        sample_valid = 1'b1;
        sample_data = 12'h111;
        @(posedge clk); #1;
        sample_data = 12'h222;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (got.size() >= 5) break;
            @(posedge clk); #1;
        end
        check("midrst reached byte4", got.size(), 5);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst wr_en", int'(fifo_if.wr_en), 0);
        check("midrst busy", int'(busy), 0);
        reset = 1'b0;
        model_seq = '0;
        n = got.size();
        repeat (5) @(posedge clk);
        #1;
        check("midrst no more bytes", got.size(), n);
        check("midrst no frame_done", int'(fd_seen), 0);
        run_frame(4'h3, 12'h333, 12'h444, 0, 1'b0, "after_rst");

        // tx_enable low with a partial frame clears it
        do_reset();
        tx_enable = 1'b1;
        sample_valid = 1'b1;
        sample_data = 12'h5A5;
        @(posedge clk); #1;
        tx_enable = 1'b0;
        sample_data = 12'h777;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        @(posedge clk); #1;
        run_frame(4'h9, 12'h3C3, 12'h0F0, 0, 1'b0, "txen");
        check("txen no overflow", int'(overflow), 0);

        // Sequence wrap over 257 frames
        do_reset();
        for (int f = 0; f < 257; f++) begin
            run_frame(4'h0, 12'h000, 12'h000, 0, 1'b0, "wrap");
            if (f == 255) check("wrap seq FF", (got.size() > 3) ? int'(got[3]) : -1, 8'hFF);
            if (f == 256) check("wrap seq 00", (got.size() > 3) ? int'(got[3]) : -1, 8'h00);
        end

        // Randomized frames with random backpressure and tx_enable during SEND
        do_reset();
        for (int f = 0; f < 40; f++) begin
            run_frame(4'($urandom), 12'($urandom), 12'($urandom), 2,
                      ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", f));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
